// File: rtl/raw10_ctrl_pkg.sv
// Shared definitions for the RAW10 CSI frame controller.
// Holds the controller state encoding and the default line/frame geometry
// (1920 px RAW10 over 4 lanes = 600 32-bit words per line, 1080 lines).
package raw10_ctrl_pkg;

  // Controller states
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWaitFs = 2'd1;
  localparam logic [1:0] StActive = 2'd2;
  localparam logic [1:0] StDrop   = 2'd3;

  localparam int unsigned DEF_WORDS_PER_LINE  = 600;
  localparam int unsigned DEF_LINES_PER_FRAME = 1080;

endpackage

// File: rtl/raw10_line_chk.sv
// Line-length checker for the RAW10 frame controller.
// Counts qualified valid cycles of one line burst and flags the line end
// (falling edge of valid) together with whether the length was correct.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - clear the counter (accepted frame start)
//   valid     - gated data-valid; one line is one contiguous burst
//   line_end  - high in the first cycle after a burst ends
//   len_ok    - at line_end: word count equals WORDS_PER_LINE and no saturation
module raw10_line_chk import raw10_ctrl_pkg::*; #(
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int unsigned CNT_W          = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic valid,
  output logic line_end,
  output logic len_ok
);

  localparam logic [CNT_W-1:0] WordsExp = CNT_W'(WORDS_PER_LINE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (valid) begin
      // Saturate; a saturated count can never be a legal length
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid & ~clr;
    end
  end

  // cnt_q still holds the burst length in the cycle valid falls
  assign line_end = valid_q & ~valid;
  assign len_ok   = (cnt_q == WordsExp) && (cnt_q != '1);

endmodule

// File: rtl/raw10_frame_ctrl.sv
// RAW10 CSI frame controller: gates CSI frame markers and payload towards the
// unpacker, checks line length and lines per frame, and counts good frames.
// All outputs are registered (1-cycle latency) or decoded from registers, so
// reset forces them to 0 asynchronously.
// Ports:
//   I_clk, I_rst                 - clock, asynchronous active-high reset
//   I_enable                     - capture arm, acted on at frame boundaries
//   I_csi_frame_start/_end       - single-cycle CSI frame markers
//   I_csi_valid, I_csi_data      - payload and qualifier
//   O_csi_frame_start/_end/valid - gated markers/qualifier to the unpacker
//   O_csi_data                   - delayed payload
//   O_busy                       - frame in progress (ACTIVE or DROP)
//   O_line_cnt                   - lines completed in current frame
//   O_frame_cnt                  - good frames passed (wrapping)
//   O_err_line_len/_frame_lines  - sticky errors, cleared at accepted frame start
//   O_err_cnt                    - errored-frame count (saturating), only when
//                                  RAW10_FRAME_CTRL_ERR_CNT_EN is defined
module raw10_frame_ctrl import raw10_ctrl_pkg::*; #(
  parameter int unsigned WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = DEF_LINES_PER_FRAME,
  parameter int unsigned CNT_W           = 12
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_enable,
  input  logic             I_csi_frame_start,
  input  logic             I_csi_frame_end,
  input  logic             I_csi_valid,
  input  logic [31:0]      I_csi_data,
  output logic             O_csi_frame_start,
  output logic             O_csi_frame_end,
  output logic             O_csi_valid,
  output logic [31:0]      O_csi_data,
  output logic             O_busy,
  output logic [CNT_W-1:0] O_line_cnt,
  output logic [15:0]      O_frame_cnt,
  output logic             O_err_line_len,
  output logic             O_err_frame_lines
`ifdef RAW10_FRAME_CTRL_ERR_CNT_EN
  ,
  output logic [15:0]      O_err_cnt
`endif
);

  localparam logic [CNT_W-1:0] LinesExp = CNT_W'(LINES_PER_FRAME);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             err_len_q, err_len_d;
  logic             err_lines_q, err_lines_d;
  logic             fs_out_q, fe_out_q, valid_out_q;
  logic [31:0]      data_out_q;

  logic in_frame, active, fs_restart, frame_close, fs_accept;
  logic line_end, len_ok;

  assign active      = (state_q == StActive);
  assign in_frame    = active || (state_q == StDrop);
  // A frame start inside a frame is an implicit frame end plus frame start
  assign fs_restart  = in_frame && I_csi_frame_start;
  assign frame_close = in_frame && (I_csi_frame_end || I_csi_frame_start);
  // After a close the controller would sit in WAIT_FS iff enabled, so the
  // same enable test covers both the normal and the restart path
  assign fs_accept   = I_csi_frame_start && I_enable &&
                       ((state_q == StWaitFs) || in_frame);

  raw10_line_chk #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .CNT_W          (CNT_W)
  ) u_line_chk (
    .clk      (I_clk),
    .rst      (I_rst),
    .clr      (fs_accept),
    .valid    (I_csi_valid & active),
    .line_end (line_end),
    .len_ok   (len_ok)
  );

  always_comb begin
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_len_d   = err_len_q;
    err_lines_d = err_lines_q;

    case (state_q)
      StIdle:   if (I_enable) state_d = StWaitFs;
      StWaitFs: if (!I_enable) state_d = StIdle;
      StActive: begin
        if (line_end) begin
          if (!len_ok) begin
            err_len_d = 1'b1;
            state_d   = StDrop;
          end else if (line_cnt_q >= LinesExp) begin
            err_lines_d = 1'b1;
            state_d     = StDrop;
          end else begin
            line_cnt_d = line_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (frame_close) begin
      state_d = I_enable ? StWaitFs : StIdle;
      if (active && !fs_restart) begin
        if (line_cnt_q != LinesExp) err_lines_d = 1'b1;
        else                        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    if (fs_accept) begin
      state_d     = StActive;
      line_cnt_d  = '0;
      err_len_d   = 1'b0;
      err_lines_d = 1'b0;
    end

    // Restart error must survive the clear of the new frame
    if (fs_restart) err_lines_d = 1'b1;
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q     <= StIdle;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      err_len_q   <= 1'b0;
      err_lines_q <= 1'b0;
      fs_out_q    <= 1'b0;
      fe_out_q    <= 1'b0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      line_cnt_q  <= line_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_len_q   <= err_len_d;
      err_lines_q <= err_lines_d;
      fs_out_q    <= fs_accept;
      fe_out_q    <= frame_close;
      valid_out_q <= active & I_csi_valid;
      data_out_q  <= active ? I_csi_data : '0;
    end
  end

`ifdef RAW10_FRAME_CTRL_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic        frame_bad;

  assign frame_bad = frame_close &&
                     (err_len_q || err_lines_q || fs_restart || (state_q == StDrop) ||
                      (line_cnt_q != LinesExp));

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      err_cnt_q <= '0;
    end else if (frame_bad && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign O_err_cnt = err_cnt_q;
`endif

  assign O_csi_frame_start = fs_out_q;
  assign O_csi_frame_end   = fe_out_q;
  assign O_csi_valid       = valid_out_q;
  assign O_csi_data        = data_out_q;
  assign O_busy            = in_frame;
  assign O_line_cnt        = line_cnt_q;
  assign O_frame_cnt       = frame_cnt_q;
  assign O_err_line_len    = err_len_q;
  assign O_err_frame_lines = err_lines_q;

endmodule
